// File: rtl/rmt_chk_pkg.sv
// Shared types and helpers for the AXI-Stream packet checker.
package rmt_chk_pkg;

    // Packet framing position: header beat, first payload beat, later payload beats.
    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_FIRST = 2'd1,
        ST_PAY   = 2'd2
    } chk_state_e;

    // First-error codes reported on err_code.
    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_KEEP = 2'd1,
        ERR_SEQ  = 2'd2,
        ERR_RUNT = 2'd3
    } err_code_e;

    // Widest counter the saturating helper supports.
    localparam int unsigned SAT_MAX_W = 64;

    // Saturating add of b onto a, clamped to the all-ones value of a w-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int unsigned          w
    );
        logic [SAT_MAX_W-1:0] max_v;
        logic [SAT_MAX_W:0]   sum;
        max_v = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
        sum   = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_v}) begin
            return max_v;
        end
        return sum[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/axis_keep_popcnt.sv
// Combinational population count of a tkeep vector.
module axis_keep_popcnt #(
    parameter int unsigned KEEP_WIDTH = 64,
    parameter int unsigned CNT_W      = $clog2(KEEP_WIDTH + 1)
) (
    input  logic [KEEP_WIDTH-1:0] keep,
    output logic [CNT_W-1:0]      count
);

    // Sum of all keep bits; synthesis balances the chain into an adder tree.
    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            count = count + CNT_W'(keep[i]);
        end
    end

endmodule

// File: rtl/rmt_axis_checker.sv
// AXI-Stream sink that counts packets/beats/bytes and checks payload
// sequence and tkeep legality, latching the first error seen.
module rmt_axis_checker
    import rmt_chk_pkg::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned CNT_WIDTH            = 64
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic                              hold,
    input  logic                              clear,
    input  logic [CNT_WIDTH-1:0]              byte_limit,
    output logic [CNT_WIDTH-1:0]              pkt_count,
    output logic [CNT_WIDTH-1:0]              beat_count,
    output logic [CNT_WIDTH-1:0]              byte_count,
    output logic [CNT_WIDTH-1:0]              err_count,
    output logic                              err_flag,
    output logic [1:0]                        err_code,
    output logic [CNT_WIDTH-1:0]              err_pkt,
    output logic                              done
);

    localparam int unsigned KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned POP_W  = $clog2(KEEP_W + 1);

    chk_state_e           state_q, state_d;
    logic [63:0]          base_q, base_d;
    logic [63:0]          idx_q, idx_d;
    logic                 rdy_q, rdy_d;
    logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
    logic [CNT_WIDTH-1:0] beat_count_q, beat_count_d;
    logic [CNT_WIDTH-1:0] byte_count_q, byte_count_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                 err_flag_q, err_flag_d;
    err_code_e            err_code_q, err_code_d;
    logic [CNT_WIDTH-1:0] err_pkt_q, err_pkt_d;

    logic                 acc;
    logic [63:0]          beat_word;
    logic                 keep_full;
    logic                 keep_contig;
    logic                 keep_bad;
    logic                 runt_err;
    logic                 seq_err;
    logic                 beat_err;
    err_code_e            beat_code;
    logic [POP_W-1:0]     keep_pop;

    // tuser and the upper data lanes are accepted but never inspected.
    logic unused_ok;
    assign unused_ok = ^{s_axis_tuser, s_axis_tdata};

    axis_keep_popcnt #(
        .KEEP_WIDTH (KEEP_W),
        .CNT_W      (POP_W)
    ) u_keep_popcnt (
        .keep  (s_axis_tkeep),
        .count (keep_pop)
    );

    assign s_axis_tready = rdy_q & ~hold;
    assign acc           = s_axis_tvalid & s_axis_tready;
    assign beat_word     = s_axis_tdata[63:0];

    // Classify the current beat: RUNT beats SEQ beats KEEP, one error per beat.
    always_comb begin
        keep_full   = &s_axis_tkeep;
        keep_contig = (s_axis_tkeep != '0) &&
                      ((s_axis_tkeep & (s_axis_tkeep + KEEP_W'(1))) == '0);
        keep_bad    = s_axis_tlast ? ~keep_contig : ~keep_full;
        runt_err    = (state_q == ST_HDR) && s_axis_tlast;
        seq_err     = (state_q == ST_PAY) && (beat_word != (base_q + idx_q));
        beat_err    = runt_err | seq_err | keep_bad;
        if (runt_err) begin
            beat_code = ERR_RUNT;
        end else if (seq_err) begin
            beat_code = ERR_SEQ;
        end else if (keep_bad) begin
            beat_code = ERR_KEEP;
        end else begin
            beat_code = ERR_NONE;
        end
    end

    // Framing FSM: advances on every accepted beat, independent of clear.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        if (acc) begin
            unique case (state_q)
                ST_HDR: begin
                    state_d = s_axis_tlast ? ST_HDR : ST_FIRST;
                end
                ST_FIRST: begin
                    base_d  = beat_word - 64'd1;
                    idx_d   = 64'd2;
                    state_d = s_axis_tlast ? ST_HDR : ST_PAY;
                end
                ST_PAY: begin
                    idx_d   = idx_q + 64'd1;
                    state_d = s_axis_tlast ? ST_HDR : ST_PAY;
                end
                default: begin
                    state_d = ST_HDR;
                end
            endcase
        end
    end

    // Statistics and first-error capture; clear overrides any same-cycle update.
    always_comb begin
        rdy_d        = 1'b1;
        pkt_count_d  = pkt_count_q;
        beat_count_d = beat_count_q;
        byte_count_d = byte_count_q;
        err_count_d  = err_count_q;
        err_flag_d   = err_flag_q;
        err_code_d   = err_code_q;
        err_pkt_d    = err_pkt_q;
        if (acc) begin
            beat_count_d = CNT_WIDTH'(sat_add(64'(beat_count_q), 64'd1, CNT_WIDTH));
            byte_count_d = CNT_WIDTH'(sat_add(64'(byte_count_q), 64'(keep_pop), CNT_WIDTH));
            pkt_count_d  = CNT_WIDTH'(sat_add(64'(pkt_count_q), 64'(s_axis_tlast), CNT_WIDTH));
            if (beat_err) begin
                err_count_d = CNT_WIDTH'(sat_add(64'(err_count_q), 64'd1, CNT_WIDTH));
                if (!err_flag_q) begin
                    err_flag_d = 1'b1;
                    err_code_d = beat_code;
                    err_pkt_d  = pkt_count_q;
                end
            end
        end
        if (clear) begin
            pkt_count_d  = '0;
            beat_count_d = '0;
            byte_count_d = '0;
            err_count_d  = '0;
            err_flag_d   = 1'b0;
            err_code_d   = ERR_NONE;
            err_pkt_d    = '0;
        end
    end

    // All state registers; reset returns framing to HDR and blocks tready.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_HDR;
            base_q       <= '0;
            idx_q        <= '0;
            rdy_q        <= 1'b0;
            pkt_count_q  <= '0;
            beat_count_q <= '0;
            byte_count_q <= '0;
            err_count_q  <= '0;
            err_flag_q   <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_pkt_q    <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            idx_q        <= idx_d;
            rdy_q        <= rdy_d;
            pkt_count_q  <= pkt_count_d;
            beat_count_q <= beat_count_d;
            byte_count_q <= byte_count_d;
            err_count_q  <= err_count_d;
            err_flag_q   <= err_flag_d;
            err_code_q   <= err_code_d;
            err_pkt_q    <= err_pkt_d;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign beat_count = beat_count_q;
    assign byte_count = byte_count_q;
    assign err_count  = err_count_q;
    assign err_flag   = err_flag_q;
    assign err_code   = err_code_q;
    assign err_pkt    = err_pkt_q;
    assign done       = (byte_count_q >= byte_limit);

endmodule

// File: tb/tb_rmt_axis_checker.sv
// Directed and randomized bench for rmt_axis_checker with a packet-level reference model.
module tb_rmt_axis_checker;

    localparam int unsigned DW = 512;
    localparam int unsigned UW = 128;
    localparam int unsigned CW = 64;
    localparam int unsigned KW = DW / 8;

    logic          clk;
    logic          aresetn;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic          hold;
    logic          clear;
    logic [CW-1:0] byte_limit;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] beat_count;
    logic [CW-1:0] byte_count;
    logic [CW-1:0] err_count;
    logic          err_flag;
    logic [1:0]    err_code;
    logic [CW-1:0] err_pkt;
    logic          done;

    rmt_axis_checker #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .CNT_WIDTH            (CW)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .hold          (hold),
        .clear         (clear),
        .byte_limit    (byte_limit),
        .pkt_count     (pkt_count),
        .beat_count    (beat_count),
        .byte_count    (byte_count),
        .err_count     (err_count),
        .err_flag      (err_flag),
        .err_code      (err_code),
        .err_pkt       (err_pkt),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position of the beat within its packet plus running totals.
    longint unsigned m_pkt, m_beat, m_byte, m_err, m_errpkt;
    bit              m_flag;
    int              m_code;
    int              m_pos;
    logic [63:0]     m_first;
    bit              m_rdy;
    bit              tog;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned sat(input longint unsigned a, input longint unsigned b);
        longint unsigned s;
        s = a + b;
        return (s < a) ? ALL1 : s;
    endfunction

    task automatic model_reset();
        m_pkt = 0; m_beat = 0; m_byte = 0; m_err = 0; m_errpkt = 0;
        m_flag = 0; m_code = 0; m_pos = 0; m_first = '0; m_rdy = 0;
    endtask

    task automatic model_clear();
        m_pkt = 0; m_beat = 0; m_byte = 0; m_err = 0; m_errpkt = 0;
        m_flag = 0; m_code = 0;
    endtask

    // Apply one clock edge to the model.
    task automatic model_edge(input bit acc, input logic [63:0] d, input logic [63:0] k,
                              input bit l, input bit clr);
        int unsigned n;
        logic [63:0] mask;
        bit kbad, runt, seq;
        int code;
        if (acc) begin
            n    = $countones(k);
            mask = (n == 64) ? ALL1 : ((64'd1 << n) - 64'd1);
            kbad = l ? (n == 0 || k != mask) : (k != ALL1);
            runt = (m_pos == 0) && l;
            seq  = (m_pos >= 2) && (d != m_first + 64'(m_pos) - 64'd1);
            code = runt ? 3 : (seq ? 2 : (kbad ? 1 : 0));
            if (code != 0) begin
                if (!m_flag) begin
                    m_flag = 1; m_code = code; m_errpkt = m_pkt;
                end
                m_err = sat(m_err, 1);
            end
            m_beat = sat(m_beat, 1);
            m_byte = sat(m_byte, n);
            if (l) m_pkt = sat(m_pkt, 1);
            if (m_pos == 1) m_first = d;
            m_pos = l ? 0 : m_pos + 1;
        end
        if (clr) model_clear();
        m_rdy = 1;
    endtask

    task automatic check_outputs();
        chk("pkt_count",  pkt_count,  m_pkt);
        chk("beat_count", beat_count, m_beat);
        chk("byte_count", byte_count, m_byte);
        chk("err_count",  err_count,  m_err);
        chk("err_flag",   64'(err_flag), 64'(m_flag));
        chk("err_code",   64'(err_code), 64'(m_code));
        chk("err_pkt",    err_pkt,    m_errpkt);
        chk("done",       64'(done),  64'(m_byte >= byte_limit));
    endtask

    // One clock: drive at the falling edge, sample tready, clock, check outputs.
    task automatic cycle(input bit v, input logic [63:0] d, input logic [63:0] k,
                         input bit l, input bit clr, input bit h, output bit acc);
        logic [DW-1:0] td;
        bit exp_rdy;
        for (int i = 0; i < int'(DW / 32); i++) td[i*32 +: 32] = $urandom;
        td[63:0]      = d;
        s_axis_tdata  = td;
        s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = v;
        clear         = clr;
        hold          = h;
        #1;
        exp_rdy = m_rdy && !h && aresetn;
        chk("tready", 64'(s_axis_tready), 64'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        model_edge(acc, d, k, l, clr);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input bit clr);
        bit a;
        cycle(0, '0, '0, 0, clr, 0, a);
        s_axis_tvalid = 0;
    endtask

    // hmode: 0 no hold, 1 hold toggles every cycle, 2 random hold.
    task automatic send(input logic [63:0] d, input logic [63:0] k, input bit l,
                        input bit clr, input int hmode);
        bit acc;
        bit h;
        int n;
        acc = 0;
        n   = 0;
        while (!acc && n < 32) begin
            case (hmode)
                1:       begin tog = !tog; h = tog; end
                2:       h = bit'($urandom_range(0, 1));
                default: h = 0;
            endcase
            cycle(1, d, k, l, clr, h, acc);
            n++;
        end
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL send_timeout: observed no accept expected accept within 32 cycles");
        end
    endtask

    task automatic send_pkt(input logic [63:0] first, input int npay, input int hmode,
                            input logic [63:0] keep_last);
        send(64'($urandom), ALL1, npay == 0, 0, hmode);
        for (int i = 0; i < npay; i++) begin
            send(first + 64'(i), (i == npay - 1) ? keep_last : ALL1, i == npay - 1, 0, hmode);
        end
    endtask

    initial begin : timeout
        #1_000_000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [63:0] v;
        logic [63:0] kl;
        int          np;
        bit          a;

        aresetn = 0; hold = 0; clear = 0; byte_limit = '0;
        s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tkeep = '0;
        s_axis_tdata = '0; s_axis_tuser = '0; tog = 0;
        model_reset();

        // Reset state, including done with a zero limit.
        @(negedge clk);
        #1;
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        check_outputs();
        chk("rst_done_lim0", 64'(done), 64'd1);
        byte_limit = 64'd3200;
        #1;
        chk("rst_done_lim3200", 64'(done), 64'd0);
        @(negedge clk);
        aresetn = 1;
        idle(0);

        // Ten clean packets, payload 2..5.
        for (int p = 0; p < 10; p++) send_pkt(64'd2, 4, 0, ALL1);
        s_axis_tvalid = 0;
        chk("clean_pkt",  pkt_count,  64'd10);
        chk("clean_beat", beat_count, 64'd50);
        chk("clean_byte", byte_count, 64'd3200);
        chk("clean_flag", 64'(err_flag), 64'd0);
        chk("clean_done", 64'(done), 64'd1);

        // Same traffic with hold toggling under continuous tvalid.
        idle(1);
        for (int p = 0; p < 10; p++) send_pkt(64'd2, 4, 1, ALL1);
        s_axis_tvalid = 0;
        idle(0);
        chk("hold_pkt",  pkt_count,  64'd10);
        chk("hold_beat", beat_count, 64'd50);
        chk("hold_byte", byte_count, 64'd3200);
        chk("hold_done", 64'(done),  64'd1);

        // Sequence error in the third packet's third payload beat.
        idle(1);
        send_pkt(64'd2, 4, 0, ALL1);
        send_pkt(64'd2, 4, 0, ALL1);
        send(64'd99, ALL1, 0, 0, 0);
        send(64'd2, ALL1, 0, 0, 0);
        send(64'd3, ALL1, 0, 0, 0);
        send(64'd9, ALL1, 0, 0, 0);
        send(64'd5, ALL1, 1, 0, 0);
        chk("seq_code", 64'(err_code), 64'd2);
        chk("seq_cnt",  err_count, 64'd1);
        chk("seq_pkt",  err_pkt,   64'd2);
        send_pkt(64'd2, 4, 0, ALL1);
        send_pkt(64'd40, 3, 0, ALL1);
        chk("seq_code_kept", 64'(err_code), 64'd2);
        chk("seq_cnt_kept",  err_count, 64'd1);

        // Illegal and legal partial last-beat keeps.
        idle(1);
        send_pkt(64'd2, 4, 0, 64'h0F0);
        chk("keep_code", 64'(err_code), 64'd1);
        idle(1);
        send_pkt(64'd2, 4, 0, 64'hFF);
        chk("keepff_byte", byte_count, 64'd264);
        chk("keepff_flag", 64'(err_flag), 64'd0);

        // Runt packet, then the next beat is a header again.
        idle(1);
        send(64'd7, ALL1, 1, 0, 0);
        chk("runt_code", 64'(err_code), 64'd3);
        chk("runt_pkt",  pkt_count, 64'd1);
        send_pkt(64'd2, 4, 0, ALL1);
        chk("runt_next_err", err_count, 64'd1);
        chk("runt_next_pkt", pkt_count, 64'd2);

        // Clear coinciding with an erroneous beat; framing continues.
        idle(1);
        send_pkt(64'd2, 4, 0, ALL1);
        send(64'd11, ALL1, 0, 0, 0);
        send(64'd2, ALL1, 0, 0, 0);
        send(64'd7, ALL1, 0, 1, 0);
        chk("clr_beat", beat_count, 64'd0);
        chk("clr_flag", 64'(err_flag), 64'd0);
        chk("clr_errs", err_count, 64'd0);
        send(64'd4, ALL1, 0, 0, 0);
        send(64'd5, ALL1, 1, 0, 0);
        chk("clr_after_err", err_count, 64'd0);
        chk("clr_after_pkt", pkt_count, 64'd1);

        // Randomized packets against the model.
        idle(1);
        for (int p = 0; p < 40; p++) begin
            np = $urandom_range(0, 5);
            v  = {$urandom, $urandom};
            send(64'($urandom), ($urandom_range(0, 9) == 0) ? 64'h7F : ALL1, np == 0,
                 $urandom_range(0, 15) == 0, 2);
            for (int i = 0; i < np; i++) begin
                case ($urandom_range(0, 3))
                    0:       kl = (64'd1 << $urandom_range(1, 63)) - 64'd1;
                    1:       kl = {$urandom, $urandom};
                    default: kl = ALL1;
                endcase
                send(($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : v + 64'(i),
                     (i == np - 1) ? kl : (($urandom_range(0, 15) == 0) ? 64'h1 : ALL1),
                     i == np - 1, $urandom_range(0, 15) == 0, 2);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 7) == 0);
        end
        s_axis_tvalid = 0;
        idle(0);

        // Asynchronous reset in the middle of a packet.
        send(64'd50, ALL1, 0, 0, 0);
        send(64'd2, ALL1, 0, 0, 0);
        s_axis_tvalid = 0;
        #1;
        aresetn = 0;
        #1;
        model_reset();
        chk("mid_rst_tready", 64'(s_axis_tready), 64'd0);
        chk("mid_rst_beat",   beat_count, 64'd0);
        chk("mid_rst_pkt",    pkt_count,  64'd0);
        chk("mid_rst_byte",   byte_count, 64'd0);
        @(posedge clk);
        @(negedge clk);
        aresetn = 1;
        send(64'd77, ALL1, 0, 0, 0);
        send(64'd2, ALL1, 0, 0, 0);
        send(64'd3, ALL1, 1, 0, 0);
        s_axis_tvalid = 0;
        idle(0);
        chk("post_rst_flag", 64'(err_flag), 64'd0);
        chk("post_rst_pkt",  pkt_count, 64'd1);
        chk("post_rst_beat", beat_count, 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rmt_axis_checker.md
# rmt_axis_checker

Synthesizable AXI-Stream sink and packet checker. It sits directly downstream of `rmt_wrapper` and consumes its 512-bit master stream. For every packet it counts packets, beats and bytes, verifies the payload sequence pattern and `tkeep` legality, and latches the first error. It replaces the simulation-only checking loop so the same checks run on hardware and in the bench.

## Interface
Parameters:
- `C_S_AXIS_DATA_WIDTH`, 512, stream data width (multiple of 64).
- `C_S_AXIS_TUSER_WIDTH`, 128, tuser width (ignored, accepted only).
- `CNT_WIDTH`, 64, width of all statistics counters.

Ports:
- `clk`  in  1  single clock.
- `aresetn`  in  1  asynchronous active-low reset.
- `s_axis_tdata`  in  C_S_AXIS_DATA_WIDTH  beat data.
- `s_axis_tkeep`  in  C_S_AXIS_DATA_WIDTH/8  byte enables.
- `s_axis_tuser`  in  C_S_AXIS_TUSER_WIDTH  unused.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tready`  out  1  beat accept.
- `s_axis_tlast`  in  1  last beat of packet.
- `hold`  in  1  forces `s_axis_tready` low (backpressure injection).
- `clear`  in  1  synchronous clear of counters and error state.
- `byte_limit`  in  CNT_WIDTH  threshold for `done`.
- `pkt_count`, `beat_count`, `byte_count`, `err_count`  out  CNT_WIDTH  statistics.
- `err_flag`  out  1  sticky: any error since reset or clear.
- `err_code`  out  2  code of first error: 0 none, 1 KEEP, 2 SEQ, 3 RUNT.
- `err_pkt`  out  CNT_WIDTH  value of `pkt_count` when the first error occurred.
- `done`  out  1  `byte_count >= byte_limit`.

## Operation
- Accept condition: `acc = s_axis_tvalid & s_axis_tready`.
- `s_axis_tready = rdy_q & ~hold`. `rdy_q` is 0 in reset and sets on the first clock after reset release.
- FSM advances only on `acc`:
  - **HDR**: beat is the header and is not checked. If `tlast`, the packet is RUNT and the FSM stays in HDR. Otherwise go to FIRST.
  - **FIRST**: latch `base = tdata[63:0] - 1` and set `idx = 2`. Go to PAY, or to HDR if `tlast`.
  - **PAY**: require `tdata[63:0] == base + idx`, else SEQ error. Increment `idx`. Go to HDR on `tlast`.
- KEEP rule, applied in all states:
  - Non-last beat: `tkeep` must be all ones.
  - Last beat: `tkeep` must be nonzero and contiguous from the LSB (`(tkeep & (tkeep+1)) == 0`).
- Error priority within one beat is RUNT > SEQ > KEEP. At most one error is counted per beat.
- Counters per accepted beat:
  - `beat_count += 1`.
  - `byte_count += popcount(tkeep)`.
  - `pkt_count += tlast`.
  - `err_count += (beat has an error)`.
- All counters saturate at all-ones; they never wrap. `idx` and `base` arithmetic is 64-bit modulo.
- On the first error, `err_code` and `err_pkt` latch and `err_flag` sets. Later errors increment `err_count` only.
- `clear`:
  - Zeroes all counters, `err_flag`, `err_code` and `err_pkt`.
  - If `clear` and an accepted beat (or its error) occur in the same cycle, `clear` wins for the counters and error state. The FSM still advances on that beat.
  - `clear` does not reset the FSM. Packet framing survives a clear.
- Reset mid-packet: the FSM returns to HDR, and the next accepted beat is treated as a header.

## Timing
- Reset values: `s_axis_tready` 0; all counters 0; `err_flag` 0; `err_code` 0; `err_pkt` 0; `done` = (`byte_limit` == 0); FSM in HDR.
- Counters, error state and FSM state update on the clock edge that accepts the beat. Outputs are visible the following cycle (1-cycle latency).
- `done` is combinational from `byte_count` and `byte_limit`.
- `hold` affects `s_axis_tready` in the same cycle; a beat is not accepted in a cycle where `hold` is high.
- Sustains one beat per cycle with no bubbles.

## Structure
- Package `rmt_chk_pkg` contains:
  - FSM state encoding (HDR, FIRST, PAY).
  - Error code constants (`ERR_NONE`, `ERR_KEEP`, `ERR_SEQ`, `ERR_RUNT`).
  - A saturating-increment function.
- Sub-module `axis_keep_popcnt`: a pipelined-free adder tree that returns `popcount(tkeep)` as 7 bits for 512-bit data.

## Test plan
- 10 packets of 1 header + 4 payload beats, all `tkeep` ones, payload `tdata` = 2..5 → `pkt_count`=10, `beat_count`=50, `byte_count`=3200, `err_flag`=0.
- Packet whose third payload beat carries 9 instead of 4 → `err_code`=2, `err_count`=1, `err_pkt` = packet index; later clean packets leave `err_code` unchanged.
- Last beat `tkeep`=0x0F0 → KEEP error; last beat `tkeep`=0xFF → no error and `byte_count` +8 for that beat.
- Single-beat packet (header with `tlast`) → `err_code`=3, `pkt_count` +1; the next beat is parsed as a header.
- `hold` toggled every other cycle while `tvalid` is held high → no beat lost or duplicated, counts match the no-`hold` run; `byte_limit`=3200 → `done` rises the cycle after the 50th beat.
- `clear` in the same cycle as an accepted erroneous beat → all counters 0 and `err_flag`=0 next cycle, and the packet's following beats still check correctly. Deassert `aresetn` mid-packet → `s_axis_tready`=0 and counters 0 immediately; the first beat after reset is treated as a header.
